// File: rtl/event_encoder_pkg.sv
// event_encoder_pkg: shared constants and helpers for the event encoder
package event_encoder_pkg;
  localparam int MAX_N = 6;
  localparam int MAX_SRC = 1 << MAX_N;
  function automatic int num_src(input int n);
    return 1 << n;
  endfunction
  function automatic logic [MAX_SRC-1:0] onehot(input logic [MAX_N-1:0] idx);
    return MAX_SRC'(1) << idx;
  endfunction
endpackage

// File: rtl/event_encoder_pick.sv
// event_pick: picks the next pending source (lowest set bit, or round-robin from ptr
// when EVENT_ENCODER_RR_EN is defined)
//   pending: pending sources   ptr: round-robin start   found: any pending   idx: chosen source
module event_pick
  import event_encoder_pkg::*;
#(
  parameter int N = 1
) (
  input  logic [2**N-1:0] pending,
  input  logic [N-1:0]    ptr,
  output logic            found,
  output logic [N-1:0]    idx
);
  localparam int S = num_src(N);
  logic [S-1:0] vec;
  logic [N-1:0] off;
`ifdef EVENT_ENCODER_RR_EN
  // rotate so ptr lands at bit 0; the offset found there maps back modulo S
  assign vec = S'({pending, pending} >> ptr);
  assign idx = off + ptr;
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign vec = pending;
  assign idx = off;
`endif
  always_comb begin
    off = '0;
    for (int i = S - 1; i >= 0; i--) off = vec[i] ? N'(i) : off;
  end
  assign found = |vec;
endmodule

// File: rtl/event_encoder.sv
// event_encoder: queues per-source event pulses and emits them one at a time as
// binary indices over a valid/ready handshake. Macro EVENT_ENCODER_RR_EN selects
// round-robin instead of lowest-index priority.
//   clk, rst_n (async, active low)   enable: allow loading the output stage
//   set: event pulses   pending: queued events
//   out_idx/out_onehot/out_valid/out_ready: output handshake
module event_encoder
  import event_encoder_pkg::*;
#(
  parameter int N = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [2**N-1:0] set,
  output logic [2**N-1:0] pending,
  output logic [N-1:0]    out_idx,
  output logic [2**N-1:0] out_onehot,
  output logic            out_valid,
  input  logic            out_ready
);
  localparam int S = num_src(N);
  logic [S-1:0] pending_q, pending_d, onehot_q, onehot_d, sel_oh, clr;
  logic [N-1:0] idx_q, idx_d, pick_idx, ptr;
  logic         valid_q, valid_d, found, free, load;
  event_pick #(.N(N)) u_pick (
    .pending(pending_q),
    .ptr    (ptr),
    .found  (found),
    .idx    (pick_idx)
  );
  always_comb begin
    sel_oh    = S'(onehot(MAX_N'(pick_idx)));
    free      = !valid_q || out_ready;
    load      = free && enable && found;
    clr       = load ? sel_oh : '0;
    // a new set pulse on the bit being granted keeps it pending
    pending_d = (pending_q & ~clr) | set;
    idx_d     = load ? pick_idx : idx_q;
    onehot_d  = load ? sel_oh : (free ? '0 : onehot_q);
    valid_d   = load || (valid_q && !out_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      onehot_q  <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      onehot_q  <= onehot_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
    end
  end
`ifdef EVENT_ENCODER_RR_EN
  logic [N-1:0] ptr_q, ptr_d;
  assign ptr_d = load ? pick_idx + N'(1) : ptr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif
  assign pending    = pending_q;
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;
  assign out_valid  = valid_q;
endmodule

// File: doc/event_encoder.md
Name: event_encoder

Overview:
- Inverse of the codebase's one-hot decoder: collects up to 2**N single-bit event pulses into a pending register and emits them one at a time as N-bit binary indices.
- Uses a valid/ready output handshake. Sits between per-source event lines (e.g. trap/interrupt causes, register-select strobes) and logic that consumes a binary index.
- Selected index is registered; each emitted event clears its own pending bit.

Parameters:
- N, 1, index width in bits. Number of sources = 2**N. Legal range 1..6.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  allows loading of a new index into the output stage
- set  input  2**N  per-source event pulse; bit i high for one cycle marks source i pending
- pending  output  2**N  current pending register
- out_idx  output  N  binary index of the granted source
- out_onehot  output  2**N  one-hot form of out_idx; all zero when out_valid=0
- out_valid  output  1  out_idx/out_onehot hold a valid event
- out_ready  input  1  consumer accepts the event when out_valid & out_ready

Behaviour:
- Reset (rst_n low, asynchronous) clears pending, out_idx, out_onehot, out_valid and the search pointer to 0. Asserting reset mid-transfer drops all queued and held events.
- Pending update at each edge: pending <= (pending & ~clr) | set.
  - clr is the one-hot of the index loaded this cycle, else 0.
  - If set and clr hit the same bit in one cycle, set wins and the bit stays pending.
- Stage free when out_valid=0 or (out_valid & out_ready).
- Load when stage free, enable=1 and |pending:
  - out_idx <= selected index
  - out_onehot <= one-hot of that index
  - out_valid <= 1
  - clr = one-hot of that index
- If the stage is free but nothing loads, out_valid <= 0 and out_onehot <= 0.
- Holding: while out_valid=1 and out_ready=0, out_idx and out_onehot are stable and no load occurs.
- Selection uses the registered pending value only; set bits sampled this cycle are not eligible.
- Latency: set pulse at edge k -> pending bit visible after k -> out_valid after edge k+1 (2 cycles) if the stage is free and enable=1.
- Throughput: one event per cycle under continuous out_ready=1.
- enable=0: pending still accumulates; a held output still completes its handshake; out_valid falls after acceptance.
- Default selection is fixed priority: lowest set index wins.
- Pointer register (log2 width N) is updated only when the optional feature is compiled in.

Optional Feature:
- Macro: EVENT_ENCODER_RR_EN.
- Defined: round-robin selection.
  - Search starts at ptr and wraps modulo 2**N.
  - On each load, ptr <= (loaded index + 1) mod 2**N; ptr wraps from 2**N-1 to 0.
- Undefined: fixed lowest-index priority; ptr logic is absent.

Decomposition:
- Shared package: function for one-hot of an N-bit index, and a constant for the number of sources.
- One natural combinational sub-module, event_pick:
  - Inputs: pending, ptr.
  - Outputs: found, idx.
  - Compiled as rotate + lowest-set search when EVENT_ENCODER_RR_EN is defined, plain lowest-set search otherwise.

Test Plan (N=2):
- Reset: assert rst_n=0 mid-cycle with pending=4'b0110, out_valid=1 -> all outputs 0 immediately; no spurious out_valid after release.
- Single event: set=4'b0100 for one cycle, out_ready=1 -> out_valid=1, out_idx=2, out_onehot=4'b0100 two cycles after pulse; next cycle out_valid=0, pending=0.
- Fixed priority: set=4'b1010 once, out_ready=1 -> indices 1 then 3 on consecutive cycles, then out_valid=0.
- Backpressure: out_ready=0 with idx 1 held; pulse set=4'b0001 -> out_idx stays 1, pending=4'b1001 (bit 1 already cleared); raise out_ready -> 1, then 0, then 3.
- Set/clear collision: pending=4'b0001 and set=4'b0001 in the load cycle -> out_idx=0 emitted, bit 0 remains pending, and a second idx 0 follows.
- With EVENT_ENCODER_RR_EN: re-pulse set=4'b1111 every cycle -> out_idx sequence 0,1,2,3,0,1 (wrap). Without the macro, the same stimulus gives 0,0,0,...
